// File: rtl/rf_alu_sequencer.sv
// rf_alu_sequencer: sequences one 32-bit instruction at a time through
// READ / EXEC / WRITE for an 8x8 register file and a combinational ALU.
// Every output is a flop, so the reg_file and ALU never see a combinational
// path from INSTR or ALU_RESULT.
module rf_alu_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [31:0]       INSTR,
  input  logic              INSTR_VALID,
  output logic              INSTR_READY,
  output logic [ADDR_W-1:0] RF_OUT1ADDR,
  output logic [ADDR_W-1:0] RF_OUT2ADDR,
  output logic [ADDR_W-1:0] RF_INADDR,
  output logic [DATA_W-1:0] RF_IN,
  output logic              RF_WE,
  output logic [2:0]        ALU_SEL,
  output logic              ALU_SUB,
  input  logic [DATA_W-1:0] ALU_RESULT,
  output logic              BUSY,
  output logic              DONE,
  output logic              ILLEGAL,
  output logic [CNT_W-1:0]  INSTR_CNT
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_t;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;

  state_t              state_q, state_d;
  logic [7:0]          op_q, op_d;
  logic [ADDR_W-1:0]   dest_q, dest_d;
  logic [ADDR_W-1:0]   src1_q, src1_d;
  logic [ADDR_W-1:0]   src2_q, src2_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                we_q, we_d;
  logic                done_q, done_d;
  logic                illegal_q, illegal_d;
  logic [2:0]          alu_sel_q, alu_sel_d;
  logic                alu_sub_q, alu_sub_d;
  logic [DATA_W-1:0]   rf_in_q, rf_in_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                accept;

  // Register-field bits above the address width are don't-care.
  logic unused_fields;
  assign unused_fields = ^{INSTR[23:16+ADDR_W], INSTR[15:8+ADDR_W]};

  // ALU control {sel, sub} for an opcode; LOADI never reaches the ALU.
  function automatic logic [3:0] alu_ctrl(input logic [7:0] op);
    case (op)
      OP_ADD:  alu_ctrl = {3'b001, 1'b0};
      OP_SUB:  alu_ctrl = {3'b001, 1'b1};
      OP_AND:  alu_ctrl = {3'b010, 1'b0};
      OP_OR:   alu_ctrl = {3'b011, 1'b0};
      default: alu_ctrl = {3'b000, 1'b0};   // MOV forwards op2
    endcase
  endfunction

  // Next state, instruction latch and the registered output values.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    dest_d    = dest_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    imm_d     = imm_q;
    illegal_d = 1'b0;
    accept    = INSTR_VALID & ready_q;

    case (state_q)
      // WRITE also accepts, so LOADIs can retire one per cycle.
      S_IDLE, S_WRITE: begin
        state_d = S_IDLE;
        if (accept) begin
          if (INSTR[31:24] > OP_OR) begin
            illegal_d = 1'b1;
          end else begin
            op_d    = INSTR[31:24];
            dest_d  = INSTR[16 +: ADDR_W];
            src1_d  = INSTR[8 +: ADDR_W];
            src2_d  = INSTR[0 +: ADDR_W];
            imm_d   = INSTR[0 +: DATA_W];
            state_d = (INSTR[31:24] == OP_LOADI) ? S_WRITE : S_READ;
          end
        end
      end
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WRITE;
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE) || (state_d == S_WRITE);
    busy_d  = (state_d != S_IDLE);
    we_d    = (state_d == S_WRITE);
    done_d  = we_d;

    if ((state_d == S_READ) || (state_d == S_EXEC)) begin
      {alu_sel_d, alu_sub_d} = alu_ctrl(op_d);
    end else begin
      {alu_sel_d, alu_sub_d} = 4'b0000;
    end

    // Entering WRITE from EXEC captures the ALU result here.
    if (we_d) begin
      rf_in_d = (op_d == OP_LOADI) ? imm_d : ALU_RESULT;
    end else begin
      rf_in_d = '0;
    end

    cnt_d = (state_q == S_WRITE) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // FSM state, instruction latch and output registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      dest_q    <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      imm_q     <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      alu_sel_q <= '0;
      alu_sub_q <= 1'b0;
      rf_in_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      dest_q    <= dest_d;
      src1_q    <= src1_d;
      src2_q    <= src2_d;
      imm_q     <= imm_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      we_q      <= we_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      alu_sel_q <= alu_sel_d;
      alu_sub_q <= alu_sub_d;
      rf_in_q   <= rf_in_d;
      cnt_q     <= cnt_d;
    end
  end

  assign INSTR_READY = ready_q;
  assign RF_OUT1ADDR = src1_q;
  assign RF_OUT2ADDR = src2_q;
  assign RF_INADDR   = dest_q;
  assign RF_IN       = rf_in_q;
  assign RF_WE       = we_q;
  assign ALU_SEL     = alu_sel_q;
  assign ALU_SUB     = alu_sub_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign ILLEGAL     = illegal_q;
  assign INSTR_CNT   = cnt_q;

endmodule
